// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates COUNT adder sums into one block total with ready/valid handshakes
module sum_accumulator #(
   parameter int WIDTH = 8,
   parameter int COUNT = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clr,
   input  logic                                 in_valid,
   input  logic [WIDTH:0]                       in_sum,
   output logic                                 in_ready,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [WIDTH+1+$clog2(COUNT)-1:0]     out_acc,
   output logic [15:0]                          out_blocks
);

   localparam int ACC_W = WIDTH + 1 + $clog2(COUNT);
   localparam int CNT_W = $clog2(COUNT);

   typedef enum logic {
      S_ACC  = 1'b0,
      S_DONE = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_acc_q, out_acc_d;
   logic [15:0]        out_blocks_q, out_blocks_d;

   logic               in_accept;
   logic               out_take;
   logic               last_sum;
   logic [ACC_W-1:0]   acc_sum;

   // Handshake qualifiers and the running sum with the incoming value zero-extended.
   assign in_accept = in_valid && (state_q == S_ACC);
   assign out_take  = out_ready && (state_q == S_DONE);
   assign last_sum  = (cnt_q == CNT_W'(COUNT - 1));
   assign acc_sum   = acc_q + ACC_W'(in_sum);

   // State register; reset lands in ACC so the block is immediately ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: clear dominates, otherwise complete a block or release a held result.
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = S_ACC;
      end else begin
         case (state_q)
            S_ACC:   if (in_accept && last_sum) state_d = S_DONE;
            S_DONE:  if (out_take) state_d = S_ACC;
            default: state_d = S_ACC;
         endcase
      end
   end

   // Datapath next values: accumulate, latch the block total, count deliveries.
   always_comb begin
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_acc_d    = out_acc_q;
      out_blocks_d = out_blocks_q;
      if (clr) begin
         acc_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else if (in_accept) begin
         if (last_sum) begin
            out_acc_d   = acc_sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (out_take) begin
         out_valid_d  = 1'b0;
         out_blocks_d = out_blocks_q + 16'd1;
      end
   end

   // Datapath registers; out_acc keeps its last total across handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_acc_q    <= '0;
         out_blocks_q <= '0;
      end else begin
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_acc_q    <= out_acc_d;
         out_blocks_q <= out_blocks_d;
      end
   end

   // Outputs: in_ready depends on state only, never on in_valid.
   always_comb begin
      in_ready   = (state_q == S_ACC);
      out_valid  = out_valid_q;
      out_acc    = out_acc_q;
      out_blocks = out_blocks_q;
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed and randomized self-checking bench for sum_accumulator
module tb_sum_accumulator;

   localparam int WIDTH = 8;
   localparam int COUNT = 4;
   localparam int ACC_W = WIDTH + 1 + $clog2(COUNT);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH:0]   in_sum = '0;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_acc;
   logic [15:0]      out_blocks;

   int checks = 0;
   int errors = 0;

   sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_sum     (in_sum),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_acc    (out_acc),
      .out_blocks (out_blocks)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit so sampling and driving stay off the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int v);
      in_valid = 1'b1;
      in_sum   = (WIDTH+1)'(v);
      step();
      in_valid = 1'b0;
   endtask

   // Reference model state for the random phase.
   int unsigned blk[$];
   int unsigned m_total;
   bit          m_done;
   int          m_blocks;
   int          accepted;
   int          cycles;
   int unsigned s;

   initial begin
      // Reset state while rst_n is held low.
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_acc", 32'(out_acc), 32'd0);
      chk("rst_out_blocks", 32'(out_blocks), 32'd0);
      step();
      rst_n = 1'b1;

      // Basic block: 10+20+30+40 with in_valid held high.
      in_valid = 1'b1;
      in_sum = 9'd10; step();
      in_sum = 9'd20; step();
      in_sum = 9'd30; step();
      chk("basic_not_yet_valid", 32'(out_valid), 32'd0);
      in_sum = 9'd40; step();
      chk("basic_out_valid", 32'(out_valid), 32'd1);
      chk("basic_out_acc", 32'(out_acc), 32'd100);
      chk("basic_in_ready", 32'(in_ready), 32'd0);

      // Backpressure: in_valid with 7s ignored while DONE holds the result.
      in_sum = 9'd7;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_out_acc", 32'(out_acc), 32'd100);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      chk("bp_release_blocks", 32'(out_blocks), 32'd1);
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_retain_out_acc", 32'(out_acc), 32'd100);

      // Max values: no truncation of 4*511.
      for (int i = 0; i < 4; i++) feed(511);
      chk("max_out_acc", 32'(out_acc), 32'd2044);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("max_blocks", 32'(out_blocks), 32'd2);

      // Clear mid-block with a coincident input handshake discarded.
      feed(100);
      feed(200);
      clr = 1'b1; in_valid = 1'b1; in_sum = 9'd50;
      step();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_blocks_kept", 32'(out_blocks), 32'd2);
      chk("clr_out_acc_kept", 32'(out_acc), 32'd2044);
      chk("clr_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) feed(1);
      chk("clr_partial_no_valid", 32'(out_valid), 32'd0);
      feed(1);
      chk("clr_out_acc", 32'(out_acc), 32'd4);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("clr_blocks_after", 32'(out_blocks), 32'd3);

      // Async reset in DONE, observed before the next clock edge.
      for (int i = 0; i < 4; i++) feed(5);
      chk("async_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_out_acc", 32'(out_acc), 32'd0);
      chk("async_out_blocks", 32'(out_blocks), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;

      // Randomized: 300 accepted sums checked against a block-sum model.
      m_done = 1'b0; m_blocks = 0; accepted = 0; cycles = 0; m_total = 0;
      blk.delete();
      while ((accepted < 300 || m_done) && cycles < 20000) begin
         in_valid  = (accepted < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_sum    = (WIDTH+1)'($urandom_range(0, 511));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_in_ready", 32'(in_ready), 32'(!m_done));
         chk("rnd_out_valid", 32'(out_valid), 32'(m_done));
         if (m_done) chk("rnd_out_acc", 32'(out_acc), m_total);
         if (!m_done && in_valid) begin
            blk.push_back(32'(in_sum));
            accepted++;
            if (blk.size() == COUNT) begin
               s = 0;
               foreach (blk[k]) s += blk[k];
               m_total = s;
               m_done = 1'b1;
               blk.delete();
            end
         end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_blocks++;
         end
         step();
         cycles++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("rnd_no_timeout", 32'(cycles < 20000), 32'd1);
      chk("rnd_model_blocks", 32'(m_blocks), 32'd75);
      chk("rnd_out_blocks", 32'(out_blocks), 32'd75);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width of the upstream Adder; sums are WIDTH+1 bits.
REQ-002 SHALL have parameter COUNT, default 4, number of sums per accumulated block; legal range 2..256.
REQ-003 SHALL derive localparam ACC_W = WIDTH+1+$clog2(COUNT) and localparam CNT_W = $clog2(COUNT); neither is overridable.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous clear of the current block.
REQ-008 in_valid  input  1  in_sum carries a valid Adder result.
REQ-009 in_sum  input  WIDTH+1  Adder sum output, including the carry bit.
REQ-010 in_ready  output  1  block can accept in_sum this cycle.
REQ-011 out_valid  output  1  out_acc holds a completed block total.
REQ-012 out_ready  input  1  downstream accepts out_acc.
REQ-013 out_acc  output  ACC_W  unsigned total of COUNT accepted sums.
REQ-014 out_blocks  output  16  count of completed blocks delivered downstream.

Function
REQ-015 SHALL implement two states: ACC (accepting input) and DONE (holding the result).
REQ-016 SHALL drive in_ready = 1 only in ACC; it is combinational from state and independent of in_valid.
REQ-017 Input accept is in_valid && in_ready at a rising edge.
  - On accept: acc <= acc + in_sum, zero-extended to ACC_W.
  - On accept: cnt <= cnt + 1.
REQ-018 SHALL sum without overflow or truncation, because ACC_W holds COUNT*(2^(WIDTH+1)-1).
REQ-019 When an accept occurs with cnt == COUNT-1:
  - SHALL load out_acc with acc + in_sum.
  - SHALL set out_valid = 1 and move to DONE on the same edge, so latency is 1 cycle from the final accept.
  - SHALL reset acc and cnt to 0.
REQ-020 In DONE, SHALL hold out_acc and out_valid stable until out_ready is high at a rising edge.
REQ-021 When out_ready is high at a rising edge in DONE:
  - SHALL clear out_valid.
  - SHALL increment out_blocks, wrapping 0xFFFF -> 0x0000.
  - SHALL return to ACC.
  - in_ready rises in the next cycle; there is no same-cycle pass-through.
REQ-022 out_ready while in ACC SHALL have no effect; in_valid while in DONE SHALL be ignored, with no accept and no state change.
REQ-023 out_acc SHALL retain its last delivered value after the handshake until the next block completes.
REQ-024 clr high at a rising edge has priority over all handshakes:
  - acc, cnt and out_valid go to 0.
  - State goes to ACC.
  - A coincident input or output handshake is discarded.
  - out_blocks and out_acc are unchanged.
REQ-025 clr or rst_n during a partially filled block SHALL discard the partial total; the next block restarts from cnt = 0.
REQ-026 in_sum SHALL be treated as unsigned; X on in_sum when in_valid is low SHALL NOT affect state.

Reset
REQ-027 rst_n low SHALL immediately, without waiting for clk, force:
  - state = ACC, acc = 0, cnt = 0;
  - out_valid = 0, out_acc = 0, out_blocks = 0;
  - therefore in_ready = 1.
REQ-028 Reset release SHALL be sampled synchronously; the first accept is possible at the first rising edge with rst_n high.

Verification
REQ-029 Basic block (WIDTH=8, COUNT=4): in_valid held high, sums 10, 20, 30, 40 -> out_valid on the cycle after the 4th accept, out_acc = 100, in_ready = 0.
REQ-030 Max values: four sums of 511 -> out_acc = 2044 (11 bits), no truncation.
REQ-031 Backpressure: out_ready held low 5 cycles in DONE with in_valid = 1 and sums of 7 -> out_acc stable at the prior total, no accept; out_ready = 1 -> out_blocks += 1, in_ready = 1 on the following cycle.
REQ-032 Clear mid-block: accept 100, 200, then pulse clr, then four sums of 1 -> out_acc = 4, out_blocks unchanged by clr.
REQ-033 Async reset: assert rst_n low between clock edges during DONE -> out_valid, out_acc and out_blocks = 0 and in_ready = 1 before the next edge.
REQ-034 Randomised check: 300 random 9-bit sums with random in_valid and out_ready -> each out_acc matches a model sum of 4 consecutive accepts; out_blocks = 75.
